// File: rtl/nand3_vector_sequencer.sv
// ---------------------------------------------------------------------------
// nand3_vector_sequencer
//
// Purpose:
//   Stimulus-and-check stage for a three-input NAND gate block. Sweeps the
//   vector {a,b,c} through 000..111 and holds each vector for HOLD_CYCLES+1
//   cycles. It samples the gate outputs d/e at the end of each hold window,
//   compares them to the expected NAND value, and counts the failing vectors.
//
// Configuration:
//   NAND3_SEQ_CHECK_EN - when defined, the compare logic, err_cnt and
//                        mismatch are built. When undefined, mismatch and
//                        err_cnt are tied to 0 and the block is a pure
//                        stimulus generator. Sweep timing is the same in
//                        both builds.
//
// Parameters:
//   HOLD_CYCLES - cycles each vector spends in DRIVE (1..255)
//   CNT_W       - width of the saturating error counter
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   begin a sweep (only honoured in IDLE)
//   d_in      in   gate output d
//   e_in      in   gate output e
//   a, b, c   out  gate inputs (a = vector MSB, c = LSB)
//   busy      out  sweep in progress, including the DONE cycle
//   done      out  one-cycle end-of-sweep pulse
//   mismatch  out  one-cycle pulse after a failing sample
//   err_cnt   out  failing vectors in the current/last sweep (saturating)
// ---------------------------------------------------------------------------
module nand3_vector_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d_in,
    input  logic             e_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The hold counter is 8 bits wide, so the largest legal HOLD_CYCLES is 255.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] vec;
    logic [2:0] vec_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;

    // Sweep accepted this cycle; also clears the error counter.
    logic       accept;

    // Next values for the registered outputs.
    logic [2:0] abc_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       samp_nxt;

    // Registered copy of "the vector now on a/b/c is in its last hold cycle".
    // The outputs lag the FSM by one register stage, so the gate result for
    // a vector is compared one edge after the FSM leaves SAMPLE. That edge
    // ends the last cycle in which the vector is visible on a/b/c.
    logic       samp_q;

    assign accept = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // State register (with the sweep datapath it steers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= 3'd0;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    vec_nxt   = 3'd0;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            DRIVE: begin
                if (hold_cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                end
            end
            SAMPLE: begin
                if (vec == 3'd7) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRIVE;
                    vec_nxt   = vec + 3'd1;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (values captured by the output register below)
    // ------------------------------------------------------------------
    always_comb begin
        abc_nxt  = 3'd0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        samp_nxt = 1'b0;
        case (state)
            DRIVE: begin
                abc_nxt  = vec;
                busy_nxt = 1'b1;
            end
            SAMPLE: begin
                abc_nxt  = vec;
                busy_nxt = 1'b1;
                samp_nxt = 1'b1;
            end
            DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                abc_nxt  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a      <= 1'b0;
            b      <= 1'b0;
            c      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            samp_q <= 1'b0;
        end else begin
            {a, b, c} <= abc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            samp_q    <= samp_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Result checker
    // ------------------------------------------------------------------
`ifdef NAND3_SEQ_CHECK_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic expected;
    logic fail;

    // a/b/c are the vector the gate is currently evaluating.
    assign expected = ~(a & b & c);
    assign fail     = (d_in != expected) || (e_in != expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mismatch <= samp_q && fail;
            if (accept) begin
                err_cnt <= '0;
            end else if (samp_q && fail && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Stimulus-only build: the gate returns are not observed.
    logic unused_gate;
    assign unused_gate = ^{d_in, e_in, samp_q, accept};
    assign mismatch    = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_nand3_vector_sequencer.sv
module tb_nand3_vector_sequencer;

`ifdef NAND3_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, start2;

    // Gate model controls: per-vector flip masks, or stuck-at overrides.
    logic [7:0] md, me;
    logic d_stk, e_stk, d_val, e_val;

    // dut1: HOLD_CYCLES=4, CNT_W=4
    logic a1, b1, c1, busy1, done1, mm1, d1, e1;
    logic [3:0] err1;
    // dut2: HOLD_CYCLES=1, CNT_W=2
    logic a2, b2, c2, busy2, done2, mm2, d2, e2;
    logic [1:0] err2;

    assign d1 = d_stk ? d_val : ((~&{a1, b1, c1}) ^ md[{a1, b1, c1}]);
    assign e1 = e_stk ? e_val : ((~&{a1, b1, c1}) ^ me[{a1, b1, c1}]);
    assign d2 = d_stk ? d_val : ((~&{a2, b2, c2}) ^ md[{a2, b2, c2}]);
    assign e2 = e_stk ? e_val : ((~&{a2, b2, c2}) ^ me[{a2, b2, c2}]);

    nand3_vector_sequencer #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .d_in(d1), .e_in(e1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .mismatch(mm1), .err_cnt(err1)
    );

    nand3_vector_sequencer #(.HOLD_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .d_in(d2), .e_in(e2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
        .mismatch(mm2), .err_cnt(err2)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Does the gate model give a wrong d or e for vector v?
    function automatic bit vec_fails(input logic [2:0] v);
        logic exp_v, dv, ev;
        exp_v = ~&v;
        dv = d_stk ? d_val : (exp_v ^ md[v]);
        ev = e_stk ? e_val : (exp_v ^ me[v]);
        return (dv !== exp_v) || (ev !== exp_v);
    endfunction

    // Runs one sweep on dut1 (sel=0) or dut2 (sel=1) and checks every cycle
    // against a timeline derived from the vector hold period P = HOLD+1:
    // cycle k after the start edge shows vector (k-1)/P for k in 1..8P,
    // DONE at k = 8P+1, mismatch for vector v at k = P*(v+1)+1.
    task automatic run_sweep(input bit sel, input bit spam, input string tag);
        int p, maxc, kend, ndone, cnt;
        bit [7:0] f;
        logic [2:0] o_abc, x_abc;
        logic o_busy, o_done, o_mm, x_busy, x_done, x_mm;
        int o_err, x_err;
        p    = sel ? 2 : 5;
        maxc = sel ? 3 : 15;
        kend = 8 * p + 4;
        for (int v = 0; v < 8; v++) f[v] = CHK && vec_fails(3'(v));
        ndone = 0;
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        step();
        for (int k = 0; k <= kend; k++) begin
            if (sel) begin
                o_abc = {a2, b2, c2}; o_busy = busy2; o_done = done2;
                o_mm = mm2; o_err = int'(err2);
            end else begin
                o_abc = {a1, b1, c1}; o_busy = busy1; o_done = done1;
                o_mm = mm1; o_err = int'(err1);
            end
            x_abc  = (k >= 1 && k <= 8 * p) ? 3'((k - 1) / p) : 3'd0;
            x_busy = (k >= 1 && k <= 8 * p + 1);
            x_done = (k == 8 * p + 1);
            x_mm   = 1'b0;
            if (k > p && k <= 8 * p + 1 && ((k - 1) % p) == 0)
                x_mm = f[(k - 1) / p - 1];
            cnt = 0;
            for (int v = 0; v < 8; v++)
                if (f[v] && k >= p * (v + 1) + 1) cnt++;
            x_err = (cnt > maxc) ? maxc : cnt;
            ndone += int'(o_done);

            checks++;
            if (o_abc !== x_abc) begin
                errors++;
                $display("FAIL %s abc k=%0d got=%0d exp=%0d", tag, k, o_abc, x_abc);
            end
            checks++;
            if (o_busy !== x_busy) begin
                errors++;
                $display("FAIL %s busy k=%0d got=%0b exp=%0b", tag, k, o_busy, x_busy);
            end
            checks++;
            if (o_done !== x_done) begin
                errors++;
                $display("FAIL %s done k=%0d got=%0b exp=%0b", tag, k, o_done, x_done);
            end
            checks++;
            if (o_mm !== x_mm) begin
                errors++;
                $display("FAIL %s mismatch k=%0d got=%0b exp=%0b", tag, k, o_mm, x_mm);
            end
            checks++;
            if (o_err !== x_err) begin
                errors++;
                $display("FAIL %s err_cnt k=%0d got=%0d exp=%0d", tag, k, o_err, x_err);
            end

            // start pulses that land while the sweep is running must be ignored
            if (sel) start2 = (spam && k <= 8 * p) ? 1'($urandom % 2) : 1'b0;
            else     start1 = (spam && k <= 8 * p) ? 1'($urandom % 2) : 1'b0;
            if (k < kend) step();
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done_count got=%0d exp=1", tag, ndone);
        end
    endtask

    task automatic gate_ok();
        md = 8'h00; me = 8'h00;
        d_stk = 1'b0; e_stk = 1'b0; d_val = 1'b0; e_val = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        gate_ok();
        step(); step();
        checks++;
        if ({a1, b1, c1, busy1, done1, mm1, err1} !== 10'd0) begin
            errors++;
            $display("FAIL reset dut1 got=%b exp=0", {a1, b1, c1, busy1, done1, mm1, err1});
        end
        checks++;
        if ({a2, b2, c2, busy2, done2, mm2, err2} !== 8'd0) begin
            errors++;
            $display("FAIL reset dut2 got=%b exp=0", {a2, b2, c2, busy2, done2, mm2, err2});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_golden();
        gate_ok();
        run_sweep(1'b0, 1'b0, "golden");
    endtask

    task automatic test_faulty_e();
        gate_ok();
        e_stk = 1'b1; e_val = 1'b1;   // only vector 111 expects 0
        run_sweep(1'b0, 1'b0, "faulty_e");
        step();
    endtask

    task automatic test_stuck();
        gate_ok();
        d_stk = 1'b1; d_val = 1'b0;   // wrong for 000..110
        e_stk = 1'b1; e_val = 1'b1;   // wrong for 111
        run_sweep(1'b0, 1'b0, "stuck");
        step();
        run_sweep(1'b1, 1'b0, "stuck_sat");
        step();
    endtask

    task automatic test_reset_mid();
        gate_ok();
        me = 8'h01;                   // vector 000 fails, so err_cnt is nonzero at reset
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 17; k++) step();   // inside vector 3's window
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({a1, b1, c1, busy1, done1, mm1, err1} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=0", {a1, b1, c1, busy1, done1, mm1, err1});
        end
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if ({a1, b1, c1, busy1, done1} !== 5'd0) begin
                errors++;
                $display("FAIL reset_mid_idle k=%0d got=%b exp=0", k, {a1, b1, c1, busy1, done1});
            end
        end
        run_sweep(1'b0, 1'b0, "restart");
        step();
    endtask

    task automatic test_back_to_back();
        gate_ok();
        run_sweep(1'b1, 1'b1, "busy_start_h1");
        step();
        run_sweep(1'b0, 1'b1, "busy_start_h4");
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            gate_ok();
            md = 8'($urandom);
            me = 8'($urandom);
            run_sweep(1'(i % 2), 1'($urandom % 2), "random");
            step();
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_faulty_e();
        test_stuck();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
